// File: rtl/fpga_robots_game_lockmon_pkg.sv
// Shared definitions for the robots-game lock monitor: state encodings and
// the counter width helper.
package fpga_robots_game_lockmon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } lock_state_e;

  // Bits needed to count 0..limit-1, never less than one bit.
  function automatic int min_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fpga_robots_game_sync.sv
// Multi-stage synchronizer for one asynchronous level into the clk domain.
module fpga_robots_game_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fpga_robots_game_lockmon.sv
// PLL lock monitor: holds the game logic in reset until every PLL has been
// stably locked, and re-asserts that reset on lock loss or soft request.
module fpga_robots_game_lockmon
  import fpga_robots_game_lockmon_pkg::*;
#(
  parameter int N_LOCK        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256,
  parameter int CNT_W         = 8,
  parameter bit FORCE_LOCKED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LOCK-1:0] pll_locked,
  input  logic              soft_rst_req,
  input  logic              clear_count,
  output logic              locked,
  output logic              game_rst_n,
  output logic [CNT_W-1:0]  lost_count,
  output logic [1:0]        state
);

  localparam int SW = min_width(SETTLE_CYCLES);
  localparam int HW = min_width(HOLD_CYCLES);

  logic all_locked;

  generate
    if (FORCE_LOCKED) begin : g_forced
      logic unused_pll;
      assign unused_pll = ^pll_locked;
      assign all_locked = 1'b1;
    end else begin : g_sync
      logic [N_LOCK-1:0] lock_sync;
      for (genvar i = 0; i < N_LOCK; i++) begin : g_bit
        fpga_robots_game_sync #(.STAGES(SYNC_STAGES)) u_sync (
          .clk   (clk),
          .rst_n (rst_n),
          .d     (pll_locked[i]),
          .q     (lock_sync[i])
        );
      end
      assign all_locked = &lock_sync;
    end
  endgenerate

  lock_state_e      cur_state, state_next;
  logic [SW-1:0]    settle_cnt, settle_next;
  logic [HW-1:0]    hold_cnt, hold_next;
  logic [CNT_W-1:0] lost_next;
  logic             armed;
  logic             loss_event;
  logic             settle_done, hold_done;

  // The settle count excludes the WAIT_LOCK cycle that first saw all_locked,
  // so SETTLE exits one count early to total SETTLE_CYCLES locked cycles.
  assign settle_done = (int'(settle_cnt) + 1 >= SETTLE_CYCLES - 1);
  assign hold_done   = (int'(hold_cnt) >= HOLD_CYCLES - 1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = cur_state;
    settle_next = settle_cnt;
    hold_next   = hold_cnt;
    loss_event  = 1'b0;
    case (cur_state)
      WAIT_LOCK: begin
        settle_next = '0;
        if (armed && all_locked) state_next = SETTLE;
      end
      SETTLE: begin
        if (!all_locked) begin
          state_next  = WAIT_LOCK;
          settle_next = '0;
        end else if (settle_done) begin
          state_next  = RUN;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + SW'(1);
        end
      end
      RUN: begin
        hold_next = '0;
        if (!all_locked) begin
          state_next = LOST;
          loss_event = 1'b1;
        end else if (soft_rst_req) begin
          state_next = LOST;
        end
      end
      LOST: begin
        if (hold_done) begin
          state_next = WAIT_LOCK;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  always_comb begin
    lost_next = lost_count;
    if (clear_count)
      lost_next = loss_event ? CNT_W'(1) : '0;
    else if (loss_event && (lost_count != '1))
      lost_next = lost_count + CNT_W'(1);
  end

  // armed delays the first FSM move until one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= WAIT_LOCK;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      locked     <= 1'b0;
      lost_count <= '0;
      armed      <= 1'b0;
    end else begin
      cur_state  <= state_next;
      settle_cnt <= settle_next;
      hold_cnt   <= hold_next;
      locked     <= (state_next == RUN);
      lost_count <= lost_next;
      armed      <= 1'b1;
    end
  end

  assign game_rst_n = locked;
  assign state      = cur_state;

endmodule
